alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
//  Hardware initiator for the ALU start/done protocol. Accepts one command (A, B, opcode)
//  on a valid/ready input and drives ALU start/A/B/opcode. Waits for done, then returns
//  result on a valid/ready output. Sits between the command source and ALU iDUT.
//  A watchdog aborts a hung operation.
// PARAMETERS
//  DATA_W     8   operand width; result is 2*DATA_W
//  TIMEOUT    64  max cycles alu_start may stay high without alu_done (>=2)
//  CNT_W      16  width of the completed-operation counter
// PORTS
//  clk         in   1         system clock, all state on rising edge
//  rst_n       in   1         asynchronous active-low reset
//  cmd_valid   in   1         command present
//  cmd_ready   out  1         issuer can take a command
//  cmd_A       in   DATA_W    operand A
//  cmd_B       in   DATA_W    operand B
//  cmd_op      in   3         operation_t opcode
//  alu_start   out  1         ALU start, held high until done/timeout
//  alu_A       out  DATA_W    ALU operand A
//  alu_B       out  DATA_W    ALU operand B
//  alu_opcode  out  3         ALU opcode
//  alu_done    in   1         ALU completion pulse
//  alu_result  in   2*DATA_W  ALU result, valid when alu_done=1
//  rsp_valid   out  1         response present
//  rsp_ready   in   1         consumer takes response
//  rsp_result  out  2*DATA_W  captured result (0 on timeout)
//  rsp_op      out  3         opcode of the completed command
//  rsp_err     out  1         1 = operation timed out
//  op_count    out  CNT_W     completed ops incl. errors; wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset: state IDLE; alu_start=0; alu_A/alu_B/alu_opcode=0; rsp_valid=0.
//   Also rsp_result=0, rsp_op=0, rsp_err=0, op_count=0; timer cleared.
//  All outputs are registered except cmd_ready, which is (state==IDLE).
//  FSM IDLE -> ISSUE -> RESP -> IDLE:
//   IDLE: cmd_valid&&cmd_ready latches A,B,op.
//    no_op (3'b000): go straight to RESP, rsp_result=0, rsp_err=0, alu_start stays 0.
//    Any other opcode (incl. rst_op 3'b111): alu_start=1 next cycle -> ISSUE.
//   ISSUE: alu_A/B/opcode stable while alu_start=1; timer counts cycles.
//    alu_done=1 sampled: capture alu_result and rsp_op, rsp_err=0.
//     alu_start=0 and rsp_valid=1 from next cycle -> RESP.
//    Timer reaches TIMEOUT without done: alu_start=0, rsp_result=0, rsp_err=1 -> RESP.
//    alu_done arriving with the timeout in the same cycle: done wins, rsp_err=0.
//   RESP: rsp_valid held with stable payload until rsp_ready. On handshake:
//    op_count++, rsp_valid=0 next cycle -> IDLE.
//    rsp_ready already high on entry: one-cycle RESP.
//  alu_done outside ISSUE is ignored: no capture, no count.
//  Min latency for an ALU op: accept@0, start@1, done@N -> rsp_valid@N+1.
//  Back-to-back: next cmd accepted the cycle after the rsp handshake.
//   alu_start is therefore low >= 1 cycle between ops.
//  Async reset mid-ISSUE drops alu_start immediately and loses the pending command.
// STRUCTURE
//  ALU_pkg: operation_t enum {no_op=3'b000, add_op, and_op, xor_op, mul_op, rst_op=3'b111}.
//   Also holds issuer_state_t {IDLE, ISSUE, RESP}.
//  One sub-module: alu_issue_timer (clear, enable, TIMEOUT compare -> expired pulse).
// TESTING
//  add_op A=8'h12 B=8'h34, ALU done 1 cycle after start -> rsp_result=16'h0046.
//   Also rsp_err=0, alu_start high exactly 1 cycle.
//  mul_op A=8'hFF B=8'hFF, done after 3 cycles -> rsp_result=16'hFE01.
//   rsp_valid 4 cycles after accept; A/B/opcode stable throughout.
//  no_op cmd -> alu_start never rises; rsp_valid next cycle, rsp_result=0, op_count+1.
//  ALU never asserts done, TIMEOUT=64 -> alu_start drops after 64 cycles.
//   rsp_err=1, rsp_result=0.
//  rsp_ready low 10 cycles after done -> payload stable, cmd_ready=0 throughout.
//   Next cmd accepted the cycle after handshake.
//  rst_n low while ISSUE -> alu_start=0 same cycle, op_count=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_cmd_issuer_pkg.sv
// alu_cmd_issuer_pkg: ALU opcodes and issuer FSM state encoding shared by the issuer RTL
package alu_cmd_issuer_pkg;
  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;
  typedef logic [1:0] issuer_state_t;
  localparam issuer_state_t IDLE  = 2'd0;
  localparam issuer_state_t ISSUE = 2'd1;
  localparam issuer_state_t RESP  = 2'd2;
endpackage

// File: rtl/alu_issue_timer.sv
// alu_issue_timer: counts enabled cycles and flags the TIMEOUT-th one
// ports: clk, rst_n (async, active low), clear (zero the count), enable (count this cycle),
//        expired (high during the TIMEOUT-th consecutive enabled cycle)
module alu_issue_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d   = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
    expired = enable && (cnt_q == TW'(TIMEOUT - 1));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: takes one command, runs it on the ALU start/done protocol, returns the result
// ports: cmd_* valid/ready command in; alu_* start/operands/opcode out with done/result back;
//        rsp_* valid/ready response out (result, opcode, timeout error); op_count completed ops
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_A,
  input  logic [DATA_W-1:0]   cmd_B,
  input  logic [2:0]          cmd_op,
  output logic                alu_start,
  output logic [DATA_W-1:0]   alu_A,
  output logic [DATA_W-1:0]   alu_B,
  output logic [2:0]          alu_opcode,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic [2:0]          rsp_op,
  output logic                rsp_err,
  output logic [CNT_W-1:0]    op_count
);
  issuer_state_t       state_q, state_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]          op_q, op_d, rop_q, rop_d;
  logic                rvalid_q, rvalid_d, err_q, err_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                expired;
  alu_issue_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != ISSUE),
    .enable  (state_q == ISSUE),
    .expired (expired)
  );
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    rop_d    = rop_q;
    rvalid_d = rvalid_q;
    err_d    = err_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        a_d  = cmd_A;
        b_d  = cmd_B;
        op_d = cmd_op;
        if (cmd_op == no_op) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          res_d    = '0;
          rop_d    = cmd_op;
          err_d    = 1'b0;
        end else begin
          state_d = ISSUE;
          start_d = 1'b1;
        end
      end
      // done has priority over an expiry landing in the same cycle
      ISSUE: if (alu_done || expired) begin
        state_d  = RESP;
        start_d  = 1'b0;
        rvalid_d = 1'b1;
        rop_d    = op_q;
        res_d    = alu_done ? alu_result : '0;
        err_d    = !alu_done;
      end
      RESP: if (rsp_ready) begin
        state_d  = IDLE;
        rvalid_d = 1'b0;
        cnt_d    = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rop_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      res_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      rop_q    <= rop_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
    end
  assign cmd_ready  = (state_q == IDLE);
  assign alu_start  = start_q;
  assign alu_A      = a_q;
  assign alu_B      = b_q;
  assign alu_opcode = op_q;
  assign rsp_valid  = rvalid_q;
  assign rsp_result = res_q;
  assign rsp_op     = rop_q;
  assign rsp_err    = err_q;
  assign op_count   = cnt_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: random and directed commands checked against a transaction-level model
module tb_alu_cmd_issuer;
  localparam int DW = 8;
  localparam int TO = 64;
  localparam int CW = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [DW-1:0] cmd_A = '0, cmd_B = '0;
  logic [2:0]    cmd_op = '0;
  logic          alu_start;
  logic [DW-1:0] alu_A, alu_B;
  logic [2:0]    alu_opcode;
  logic          alu_done = 1'b0;
  logic [2*DW-1:0] alu_result = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [2*DW-1:0] rsp_result;
  logic [2:0]    rsp_op;
  logic [CW-1:0] op_count;
  int checks = 0, errors = 0, exp_count = 0;
  alu_cmd_issuer #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_op(cmd_op),
    .alu_start(alu_start), .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_op(rsp_op), .rsp_err(rsp_err), .op_count(op_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [2*DW-1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd1:    return (2*DW)'(a) + (2*DW)'(b);
      3'd2:    return (2*DW)'(a & b);
      3'd3:    return (2*DW)'(a ^ b);
      3'd4:    return (2*DW)'(a) * (2*DW)'(b);
      default: return '0;
    endcase
  endfunction
  // lat: cycle (accept = 0) in which the ALU pulses done; 0 = never. hold: cycles rsp_ready stays low.
  task automatic run_cmd(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int lat, input int hold);
    logic [2*DW-1:0] res, exp_res;
    logic exp_err;
    int exp_hi, highs, n;
    res = alu_fn(op, a, b);
    if (op == 3'd0) begin exp_hi = 0; exp_err = 1'b0; exp_res = '0; end
    else if (lat >= 1 && lat <= TO) begin exp_hi = lat; exp_err = 1'b0; exp_res = res; end
    else begin exp_hi = TO; exp_err = 1'b1; exp_res = '0; end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_A = a; cmd_B = b; cmd_op = op;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_A = DW'($urandom); cmd_B = DW'($urandom); cmd_op = 3'($urandom);
    highs = 0;
    n = 1;
    while (alu_start === 1'b1 && n <= TO + 2) begin
      highs++;
      chk("alu_operands", {alu_A, alu_B, alu_opcode}, {a, b, op});
      chk("cmd_ready_busy", cmd_ready, 0);
      if (n == lat) begin alu_done = 1'b1; alu_result = res; end
      @(negedge clk);
      alu_done = 1'b0; alu_result = (2*DW)'($urandom);
      n++;
    end
    chk("start_cycles", highs, exp_hi);
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_result", rsp_result, exp_res);
      chk("rsp_err", rsp_err, exp_err);
      chk("rsp_op", rsp_op, op);
      chk("cmd_ready_resp", cmd_ready, 0);
      chk("start_resp", alu_start, 0);
      if (i == hold) rsp_ready = 1'b1;
      else begin alu_done = 1'($urandom); alu_result = (2*DW)'($urandom); end
      @(negedge clk);
      alu_done = 1'b0; rsp_ready = 1'b0;
    end
    exp_count++;
    chk("rsp_valid_done", rsp_valid, 0);
    chk("op_count", op_count, CW'(exp_count));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    int r, lat;
    repeat (3) @(negedge clk);
    chk("rst_start", alu_start, 0);
    chk("rst_operands", {alu_A, alu_B, alu_opcode}, 0);
    chk("rst_rsp", {rsp_valid, rsp_result, rsp_op, rsp_err}, 0);
    chk("rst_count", op_count, 0);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(3'd1, 8'h12, 8'h34, 1, 0);
    run_cmd(3'd4, 8'hFF, 8'hFF, 3, 0);
    run_cmd(3'd0, 8'h5A, 8'hA5, 1, 0);
    run_cmd(3'd1, 8'h01, 8'h02, 0, 0);
    run_cmd(3'd3, 8'hF0, 8'h3C, 2, 10);
    run_cmd(3'd2, 8'hCC, 8'hAA, TO, 1);
    run_cmd(3'd7, 8'h11, 8'h22, TO + 1, 0);
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      lat = r < 7 ? int'($urandom_range(1, 6)) : r == 7 ? TO : r == 8 ? 0 : TO - 1;
      run_cmd(3'($urandom), DW'($urandom), DW'($urandom), lat, int'($urandom_range(0, 3)));
    end
    cmd_valid = 1'b1; cmd_A = 8'h33; cmd_B = 8'h44; cmd_op = 3'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_start", alu_start, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_start", alu_start, 0);
    chk("mid_rst_count", op_count, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_start", alu_start, 0);
    run_cmd(3'd4, 8'h10, 8'h10, 2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
